line_fill_responder: RTL and testbench

// - Backing-store responder on the far side of the IR and MEM cache line interface.
// - Accepts one line request at a time: a fill (read) or a writeback (write).
// - Fills stream out as 8 consecutive 32-bit beats after a fixed latency; writebacks absorb 8 beats.
// - Sits below the cache FSMs, replacing the combinational IR_MEM word bank with a timed memory.

---
 rtl/line_fill_responder_if.sv | 22 ++
 rtl/line_fill_responder.sv | 74 +++++++
 tb/tb_line_fill_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/line_fill_responder_if.sv
// line_fill_responder_if: request, writeback-beat and fill-beat signals between a cache and its line responder
interface line_fill_responder_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WE;
   logic [31:0] REQ_ADDR;
   logic [31:0] WR_DATA;
   logic        WR_VALID;
   logic [31:0] RD_DATA;
   logic        RD_VALID;
   logic        RD_LAST;
   logic        WR_DONE;
   logic        BUSY;
   modport master (
      output REQ_VALID, REQ_WE, REQ_ADDR, WR_DATA, WR_VALID,
      input  REQ_READY, RD_DATA, RD_VALID, RD_LAST, WR_DONE, BUSY
   );
   modport slave (
      input  REQ_VALID, REQ_WE, REQ_ADDR, WR_DATA, WR_VALID,
      output REQ_READY, RD_DATA, RD_VALID, RD_LAST, WR_DONE, BUSY
   );
endinterface

// File: rtl/line_fill_responder.sv
// line_fill_responder: timed backing-store line responder (fills after fixed latency, writebacks absorbed in order)
// Define CRITICAL_WORD_FIRST_EN to start fills at the requested word and wrap around the line.
module line_fill_responder #(
   parameter int    WORDS_PER_LINE = 8,
   parameter int    DEPTH_WORDS    = 4096,
   parameter int    READ_LATENCY   = 4,
   parameter string INIT_FILE      = ""
) (
   input logic CLK,
   input logic RST,
   line_fill_responder_if.slave bus
);
   localparam int BW = $clog2(WORDS_PER_LINE);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int LW = 30 - BW;
   typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK} state_t;
   state_t          state, state_n;
   logic [3:0]      cnt;
   logic [BW-1:0]   beat, beat_n, word_q, word_n, start;
   logic [LW-1:0]   line_q, line_n;
   logic [31:0]     mem [DEPTH_WORDS];
   logic [31:0]     rd_data;
   logic            accept;
   assign accept = state == IDLE && bus.REQ_VALID;
`ifdef CRITICAL_WORD_FIRST_EN
   assign start = bus.REQ_ADDR[BW+1:2];
`else
   assign start = '0;
`endif
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (bus.REQ_VALID) state_n = bus.REQ_WE ? WR_BURST : (READ_LATENCY == 0 ? RD_BURST : WAIT);
         WAIT:     if (cnt == 4'd1) state_n = RD_BURST;
         RD_BURST: if (&beat) state_n = IDLE;
         WR_BURST: if (bus.WR_VALID && &beat) state_n = WR_ACK;
         default:  state_n = IDLE;
      endcase
   end
   always_comb begin
      bus.REQ_READY = state == IDLE;
      bus.BUSY      = state != IDLE;
      bus.RD_VALID  = state == RD_BURST;
      bus.RD_LAST   = state == RD_BURST && &beat;
      bus.RD_DATA   = state == RD_BURST ? rd_data : '0;
      bus.WR_DONE   = state == WR_ACK;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt    <= '0;
         beat   <= '0;
         word_q <= '0;
         line_q <= '0;
      end else if (accept) begin
         cnt    <= 4'(READ_LATENCY);
         beat   <= '0;
         word_q <= start;
         line_q <= bus.REQ_ADDR[31:BW+2];
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      else if (state == RD_BURST || (state == WR_BURST && bus.WR_VALID)) beat <= beat + BW'(1);
   end
   // The beat entering RD_BURST is fetched one edge early, so the request address is used directly at accept.
   assign beat_n = state == RD_BURST ? beat + BW'(1) : '0;
   assign line_n = state == IDLE ? bus.REQ_ADDR[31:BW+2] : line_q;
   assign word_n = (state == IDLE ? start : word_q) + beat_n;
   always_ff @(posedge CLK) begin
      if (state == WR_BURST && bus.WR_VALID) mem[AW'({line_q, beat})] <= bus.WR_DATA;
      if (state_n == RD_BURST) rd_data <= mem[AW'({line_n, word_n})];
   end
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: scoreboard bench for line_fill_responder (latency 4 main instance, latency 0 shadow)
module tb_line_fill_responder;
   localparam int L = 4;
   logic CLK = 0;
   logic RST = 0;
   always #5 CLK = ~CLK;
   line_fill_responder_if bus();
   line_fill_responder_if bus0();
   line_fill_responder #(.READ_LATENCY(L)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
   line_fill_responder #(.READ_LATENCY(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
   assign bus0.REQ_VALID = bus.REQ_VALID;
   assign bus0.REQ_WE    = bus.REQ_WE;
   assign bus0.REQ_ADDR  = bus.REQ_ADDR;
   assign bus0.WR_DATA   = bus.WR_DATA;
   assign bus0.WR_VALID  = bus.WR_VALID;
   typedef struct {logic [31:0] d; logic l;} beat_t;
   beat_t       exp_q[$];
   logic [31:0] mdl [4096];
   int          n_chk = 0;
   int          n_pass = 0;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask
   function automatic int idx(logic [31:0] a, int w);
      return ((int'(a >> 5) << 3) + w) & 4095;
   endfunction
   task automatic push_fill(logic [31:0] a);
      int s;
`ifdef CRITICAL_WORD_FIRST_EN
      s = int'(a[4:2]);
`else
      s = 0;
`endif
      for (int b = 0; b < 8; b++) exp_q.push_back('{mdl[idx(a, (s + b) % 8)], b == 7});
   endtask
   always @(posedge CLK) begin
      #1;
      if (bus.RD_VALID) begin : pop
         beat_t e;
         if (exp_q.size() == 0) check("rd_unexpected", 32'(bus.RD_VALID), 0);
         else begin
            e = exp_q.pop_front();
            check("rd_data", bus.RD_DATA, e.d);
            check("rd_last", 32'(bus.RD_LAST), 32'(e.l));
         end
      end
   end
   task automatic wb(logic [31:0] a, logic [31:0] base, int gap);
      @(negedge CLK);
      bus.REQ_VALID = 1; bus.REQ_WE = 1; bus.REQ_ADDR = a;
      @(negedge CLK);
      bus.REQ_VALID = 0;
      for (int k = 0; k < 8; k++) begin
         bus.WR_VALID = 1; bus.WR_DATA = base + 32'(k);
         mdl[idx(a, k)] = base + 32'(k);
         @(negedge CLK);
         if (k == 3) begin
            bus.WR_VALID = 0; bus.WR_DATA = 32'hDEAD_BEEF;
            for (int g = 0; g < gap; g++) begin
               @(negedge CLK);
               check("wr_done_early", 32'(bus.WR_DONE), 0);
            end
         end
      end
      bus.WR_VALID = 0;
      check("wr_done", 32'(bus.WR_DONE), 1);
      @(negedge CLK);
      check("wr_done_pulse", 32'(bus.WR_DONE), 0);
      check("ready_after_wb", 32'(bus.REQ_READY), 1);
   endtask
   task automatic fill(logic [31:0] a);
      int i, n;
      @(negedge CLK);
      bus.REQ_VALID = 1; bus.REQ_WE = 0; bus.REQ_ADDR = a;
      push_fill(a);
      @(negedge CLK);
      bus.REQ_VALID = 0;
      check("ready_low", 32'(bus.REQ_READY), 0);
      check("l0_valid", 32'(bus0.RD_VALID), 1);
      check("l0_data", bus0.RD_DATA, exp_q[0].d);
      for (i = 0; i < 20; i++) begin
         if (bus.RD_VALID) break;
         @(negedge CLK);
      end
      check("latency", 32'(i), L);
      for (n = 0; n < 16 && bus.RD_VALID; n++) @(negedge CLK);
      check("burst_len", 32'(n), 8);
      check("ready_after_rd", 32'(bus.REQ_READY), 1);
   endtask
   initial begin
      int i;
      bus.REQ_VALID = 0; bus.REQ_WE = 0; bus.REQ_ADDR = 0; bus.WR_DATA = 0; bus.WR_VALID = 0;
      #2 RST = 1;
      #2;
      check("rst_ready", 32'(bus.REQ_READY), 1);
      check("rst_rd_valid", 32'(bus.RD_VALID), 0);
      check("rst_rd_last", 32'(bus.RD_LAST), 0);
      check("rst_rd_data", bus.RD_DATA, 0);
      check("rst_wr_done", 32'(bus.WR_DONE), 0);
      check("rst_busy", 32'(bus.BUSY), 0);
      @(negedge CLK);
      RST = 0;
      wb(32'h100, 32'hA0, 0);
      fill(32'h100);
      wb(32'h200, 32'h11, 2);
      fill(32'h200);
      // request held high across a whole fill is taken again only once READY returns
      @(negedge CLK);
      bus.REQ_VALID = 1; bus.REQ_WE = 0; bus.REQ_ADDR = 32'h200;
      push_fill(32'h200);
      push_fill(32'h200);
      for (i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.REQ_READY) break;
      end
      check("hold_ready_cycle", 32'(i), L + 8);
      @(negedge CLK);
      check("reaccept", 32'(bus.BUSY), 1);
      bus.REQ_VALID = 0;
      for (i = 0; i < 40 && bus.BUSY; i++) @(negedge CLK);
      check("hold_idle", 32'(bus.BUSY), 0);
      // reset while beat 3 of a fill is on the bus
      @(negedge CLK);
      bus.REQ_VALID = 1; bus.REQ_WE = 0; bus.REQ_ADDR = 32'h100;
      push_fill(32'h100);
      @(negedge CLK);
      bus.REQ_VALID = 0;
      for (i = 0; i < 20 && !bus.RD_VALID; i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      check("beat3_valid", 32'(bus.RD_VALID), 1);
      RST = 1;
      #1;
      check("mid_rst_rd_valid", 32'(bus.RD_VALID), 0);
      check("mid_rst_rd_data", bus.RD_DATA, 0);
      check("mid_rst_busy", 32'(bus.BUSY), 0);
      check("mid_rst_ready", 32'(bus.REQ_READY), 1);
      exp_q.delete();
      @(negedge CLK);
      RST = 0;
      fill(32'h100);
      fill(32'h10C);
      fill(32'h4100);
      repeat (2) @(negedge CLK);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
